ga_chrom_queue: RTL and testbench

Chromosome buffer between the mutation stage and the next-generation population writer. Each push from the mutation stage captures either the original child chromosome or its mutated version, selected per push, into a circular FIFO. The read side hands chromosomes one at a time to the population writer over a valid/ack handshake. The block also counts popped chromosomes and emits a one-cycle generation-done pulse after a full population has been drained.

---
 rtl/ga_chrom_queue.sv | 126 ++++++++++++
 tb/tb_ga_chrom_queue.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ga_chrom_queue.sv
// Chromosome FIFO between the mutation stage and the population writer,
// with a per-generation pop counter that pulses gen_done after pop_size pops.
module ga_chrom_queue #(
  parameter int unsigned CHROM_W     = 32,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned POP_W       = 8,
  parameter int          SIM_DLY     = 1
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             sw_rst,
  input  logic                             queue_push,
  input  logic                             queue_chrom_sel,
  input  logic [CHROM_W-1:0]               child_chrom,
  input  logic [CHROM_W-1:0]               mut_chrom,
  input  logic [POP_W-1:0]                 pop_size,
  output logic                             out_valid,
  output logic [CHROM_W-1:0]               out_chrom,
  input  logic                             out_ack,
  output logic [$clog2(QUEUE_DEPTH):0]     queue_cnt,
  output logic                             queue_full,
  output logic                             queue_ovf,
  output logic                             gen_done
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  // Flop delays are a simulation-only concern; the value is only range-checked here.
  if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) || (SIM_DLY < 0)) begin : g_bad_param
    $error("ga_chrom_queue: QUEUE_DEPTH must be a power of two >= 2 and SIM_DLY >= 0");
  end

  typedef enum logic {GEN_IDLE_ST, GEN_FILL_ST} gen_st_e;

  logic [CHROM_W-1:0] mem_q [QUEUE_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               pop_w, push_ok_w, push_rej_w;
  logic [CHROM_W-1:0] wr_data_w;

  gen_st_e            gen_st_q;
  logic [POP_W-1:0]   pop_cntr_q;
  logic               gen_done_q;

  always_comb begin
    pop_w      = (cnt_q != '0) && out_ack;
    push_ok_w  = queue_push && ((cnt_q != DEPTH_C) || pop_w);
    push_rej_w = queue_push && !push_ok_w;
    wr_data_w  = queue_chrom_sel ? mut_chrom : child_chrom;
    wr_ptr_d   = push_ok_w ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_w ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d      = cnt_q;
    if (push_ok_w && !pop_w) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!push_ok_w && pop_w) begin
      cnt_d = cnt_q - CW'(1);
    end
    ovf_d = ovf_q | push_rej_w;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
    end else if (sw_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      if (push_ok_w) mem_q[wr_ptr_q] <= wr_data_w;
    end
  end

  // ">=" lets a generation end early if pop_size shrank between generations.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gen_st_q   <= GEN_IDLE_ST;
      pop_cntr_q <= '0;
      gen_done_q <= 1'b0;
    end else if (sw_rst) begin
      gen_st_q   <= GEN_IDLE_ST;
      pop_cntr_q <= '0;
      gen_done_q <= 1'b0;
    end else begin
      gen_done_q <= 1'b0;
      if (pop_w) begin
        case (gen_st_q)
          GEN_IDLE_ST: begin
            pop_cntr_q <= POP_W'(1);
            gen_st_q   <= GEN_FILL_ST;
          end
          default: begin
            if (pop_cntr_q >= pop_size - POP_W'(1)) begin
              pop_cntr_q <= '0;
              gen_done_q <= 1'b1;
              gen_st_q   <= GEN_IDLE_ST;
            end else begin
              pop_cntr_q <= pop_cntr_q + POP_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign out_valid  = (cnt_q != '0);
  assign out_chrom  = mem_q[rd_ptr_q];
  assign queue_cnt  = cnt_q;
  assign queue_full = (cnt_q == DEPTH_C);
  assign queue_ovf  = ovf_q;
  assign gen_done   = gen_done_q;

endmodule

// File: tb/tb_ga_chrom_queue.sv
// Directed bench for ga_chrom_queue; a scoreboard queue holds the expected
// FIFO contents and a small counter model predicts gen_done.
module tb_ga_chrom_queue;

  localparam int unsigned CHROM_W = 32;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned POP_W   = 8;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               sw_rst = 1'b0;
  logic               queue_push = 1'b0;
  logic               queue_chrom_sel = 1'b0;
  logic [CHROM_W-1:0] child_chrom = '0;
  logic [CHROM_W-1:0] mut_chrom = '0;
  logic [POP_W-1:0]   pop_size = 8'd5;
  logic               out_valid;
  logic [CHROM_W-1:0] out_chrom;
  logic               out_ack = 1'b0;
  logic [CW-1:0]      queue_cnt;
  logic               queue_full;
  logic               queue_ovf;
  logic               gen_done;

  ga_chrom_queue #(
    .CHROM_W    (CHROM_W),
    .QUEUE_DEPTH(DEPTH),
    .POP_W      (POP_W),
    .SIM_DLY    (1)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .sw_rst         (sw_rst),
    .queue_push     (queue_push),
    .queue_chrom_sel(queue_chrom_sel),
    .child_chrom    (child_chrom),
    .mut_chrom      (mut_chrom),
    .pop_size       (pop_size),
    .out_valid      (out_valid),
    .out_chrom      (out_chrom),
    .out_ack        (out_ack),
    .queue_cnt      (queue_cnt),
    .queue_full     (queue_full),
    .queue_ovf      (queue_ovf),
    .gen_done       (gen_done)
  );

  always #5 clk = ~clk;

  logic [CHROM_W-1:0] exp_q [$];
  int          checks   = 0;
  int          failures = 0;
  int          mpc      = 0;
  int          ps       = 5;
  bit          mgd      = 1'b0;
  bit          movf     = 1'b0;
  int unsigned n        = 0;
  int          gd_seen  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    chk("queue_cnt", 64'(queue_cnt), 64'(exp_q.size()));
    chk("queue_full", 64'(queue_full), 64'(exp_q.size() == DEPTH));
    chk("queue_ovf", 64'(queue_ovf), 64'(movf));
    chk("gen_done", 64'(gen_done), 64'(mgd));
    if (gen_done === 1'b1) gd_seen++;
    if (exp_q.size() > 0) chk("out_chrom", 64'(out_chrom), 64'(exp_q[0]));
  endtask

  // One clock: drive, predict, clock, sample #1 after the edge, compare.
  task automatic step(input bit push, input bit sel, input bit ack, input bit srst);
    logic [CHROM_W-1:0] c, m;
    bit pop, acc;
    c = 32'hC0DE_0000 | n;
    m = 32'h5A5A_0000 | n;
    n++;
    queue_push = push; queue_chrom_sel = sel; child_chrom = c; mut_chrom = m;
    out_ack = ack; sw_rst = srst;
    pop = ack && (exp_q.size() > 0);
    acc = push && ((exp_q.size() < DEPTH) || pop);
    @(posedge clk);
    #1;
    if (srst) begin
      exp_q.delete();
      movf = 1'b0; mpc = 0; mgd = 1'b0;
    end else begin
      mgd = 1'b0;
      if (pop) begin
        void'(exp_q.pop_front());
        if (mpc + 1 >= ps) begin mpc = 0; mgd = 1'b1; end
        else mpc++;
      end
      if (acc) exp_q.push_back(sel ? m : c);
      else if (push) movf = 1'b1;
    end
    queue_push = 1'b0; out_ack = 1'b0; sw_rst = 1'b0;
    check_outputs();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", 64'(queue_cnt), 64'd0);
    chk("rst_full", 64'(queue_full), 64'd0);
    chk("rst_ovf", 64'(queue_ovf), 64'd0);
    chk("rst_gen_done", 64'(gen_done), 64'd0);
    chk("rst_chrom", 64'(out_chrom), 64'd0);
    rstn = 1'b1;

    // Ordering: A child, B mutated, C child, then three acks.
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("order_cnt3", 64'(queue_cnt), 64'd3);
    repeat (3) step(0, 0, 1, 0);

    // Fill to 8, then a rejected 9th push; ovf stays set on an idle cycle.
    for (int i = 0; i < 8; i++) step(1, i[0], 0, 0);
    chk("full_flag", 64'(queue_full), 64'd1);
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("ovf_sticky", 64'(queue_ovf), 64'd1);

    // Push with ack at full: no overflow growth, count stays 8; drain all.
    step(1, 1, 1, 0);
    chk("full_pushpop_cnt", 64'(queue_cnt), 64'd8);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 1);

    // Wrap-around: one resident entry, 20 push+ack cycles.
    step(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, i[1], 1, 0);
      chk("wrap_cnt1", 64'(queue_cnt), 64'd1);
    end
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);

    // Generation pulses: 12 pops with pop_size=5.
    gd_seen = 0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, i[0], 1, 0);
    step(0, 0, 0, 0);
    chk("gen_pulses_12pops", 64'(gd_seen), 64'd2);
    step(0, 0, 0, 1);

    // Mid-generation soft reset with push and ack asserted.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0);
    step(1, 1, 1, 1);
    chk("srst_valid", 64'(out_valid), 64'd0);
    chk("srst_cnt", 64'(queue_cnt), 64'd0);
    gd_seen = 0;
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0);
    chk("srst_gen_after5", 64'(gd_seen), 64'd1);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
